// File: rtl/fifo_tree_pkg.sv
// Shared types and constants for the FIFO tree scheduler.
// Holds the scheduler state enum, tree geometry and a popcount helper.
package fifo_tree_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RECOVER
  } sched_state_t;

  localparam int LOAD_CYCLES = 5;
  localparam int TREE_GROUPS = 4;
  localparam int GROUP_SIZE  = 5;

  function automatic int popcount(
    input logic [TREE_GROUPS*GROUP_SIZE-1:0] m
  );
    int n;
    n = 0;
    for (int i = 0; i < TREE_GROUPS*GROUP_SIZE; i++)
      n += int'(m[i]);
    return n;
  endfunction

endpackage

// File: rtl/fifo_tree_sched_if.sv
// Bundle of batch, tree and consumer signals around the scheduler.
// slave: scheduler side; master: fetch stage, tree and consumer side.
interface fifo_tree_sched_if #(
  parameter int CW = 36,
  parameter int CC = 20,
  parameter int OW = 7
);
  logic [CW*CC-1:0] batch_clauses_i;
  logic [CC-1:0]    batch_mask_i;
  logic             batch_req_i;
  logic             batch_ack_o;
  logic             flush_i;
  logic [CW*CC-1:0] tree_clauses_o;
  logic [CC-1:0]    tree_mask_o;
  logic             tree_wren_o;
  logic             tree_rden_o;
  logic             tree_cof_o;
  logic             tree_empty_i;
  logic             tree_of_i;
  logic [CW-1:0]    tree_clause_i;
  logic [CW-1:0]    clause_o;
  logic             clause_valid_o;
  logic             clause_ready_i;
  logic             busy_o;
  logic             of_event_o;
  logic [OW-1:0]    occ_o;

  modport slave (
    input  batch_clauses_i, batch_mask_i,
    input  batch_req_i, flush_i,
    input  tree_empty_i, tree_of_i,
    input  tree_clause_i, clause_ready_i,
    output batch_ack_o, tree_clauses_o,
    output tree_mask_o, tree_wren_o,
    output tree_rden_o, tree_cof_o,
    output clause_o, clause_valid_o,
    output busy_o, of_event_o, occ_o
  );

  modport master (
    output batch_clauses_i, batch_mask_i,
    output batch_req_i, flush_i,
    output tree_empty_i, tree_of_i,
    output tree_clause_i, clause_ready_i,
    input  batch_ack_o, tree_clauses_o,
    input  tree_mask_o, tree_wren_o,
    input  tree_rden_o, tree_cof_o,
    input  clause_o, clause_valid_o,
    input  busy_o, of_event_o, occ_o
  );
endinterface

// File: rtl/fifo_sched_skid.sv
// Circular valid/ready skid buffer with synchronous flush.
// Ports: clk, reset, clear, push/din in, ready/dout/valid out, count.
module fifo_sched_skid #(
  parameter int DEPTH = 4,
  parameter int W     = 36,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          ready,
  output logic [W-1:0]  dout,
  output logic          valid,
  output logic [CW-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          pop;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign valid = (count != '0);
  assign pop   = valid && ready;
  // Empty head reads as zero so the port is clean out of reset.
  assign dout  = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop)
        rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/fifo_tree_sched.sv
// Batch admission, load pacing, drain and OF/flush recovery for a FIFO tree.
// Ports: clk, reset (sync, high), bus (slave); stats via FIFO_SCHED_STATS_EN.
module fifo_tree_sched
  import fifo_tree_pkg::*;
#(
  parameter int CLAUSE_COUNT = 20,
  parameter int CLAUSE_WIDTH = 36,
  parameter int OCC_LIMIT    = 24,
  parameter int RD_LAT       = 1,
  parameter int SKID_DEPTH   = 4,
  parameter int OW = $clog2(OCC_LIMIT + CLAUSE_COUNT) + 1
) (
  input logic clk,
  input logic reset,
  fifo_tree_sched_if.slave bus
`ifdef FIFO_SCHED_STATS_EN
  ,
  output logic [31:0] batch_count_o,
  output logic [31:0] clause_in_count_o,
  output logic [31:0] clause_out_count_o,
  output logic [15:0] of_count_o
`endif
);
  localparam int SCW = $clog2(SKID_DEPTH + 1);

  sched_state_t      state;
  logic [2:0]        load_cnt;
  logic [OW-1:0]     occ;
  logic [OW-1:0]     pop_cnt;
  logic [OW-1:0]     occ_sum;
  logic [OW-1:0]     occ_next;
  logic [RD_LAT-1:0] rd_pipe;
  logic [SCW-1:0]    skid_count;
  logic              ack;
  logic              wren;
  logic              cof;
  logic              of_ev;
  logic              flush_drop;
  logic              rden;
  logic              accept;
  logic              skid_clear;
  logic [CLAUSE_WIDTH*CLAUSE_COUNT-1:0] clauses_q;
  logic [CLAUSE_COUNT-1:0] mask_q;
  int                inflight;

  always_comb begin
    inflight = 0;
    for (int i = 0; i < RD_LAT; i++)
      inflight += int'(rd_pipe[i]);
  end

  assign pop_cnt = OW'(popcount(bus.batch_mask_i));

  // Space is reserved for reads still in flight.
  assign rden = !reset && !bus.tree_empty_i
             && (int'(skid_count) + inflight < SKID_DEPTH);

  // ack gates a re-accept while the requester has not yet dropped req.
  assign accept = (state == IDLE) && bus.batch_req_i
               && !ack && !bus.tree_of_i && !bus.flush_i
               && (occ + pop_cnt <= OW'(OCC_LIMIT));

  assign occ_sum  = occ + (accept ? pop_cnt : '0);
  assign occ_next = (rden && occ_sum != '0)
                  ? occ_sum - OW'(1) : occ_sum;

  // A flush keeps discarding tree data until recovery completes.
  assign skid_clear = bus.flush_i || flush_drop;

  fifo_sched_skid #(
    .DEPTH (SKID_DEPTH),
    .W     (CLAUSE_WIDTH)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .clear (skid_clear),
    .push  (rd_pipe[RD_LAT-1]),
    .din   (bus.tree_clause_i),
    .ready (bus.clause_ready_i),
    .dout  (bus.clause_o),
    .valid (bus.clause_valid_o),
    .count (skid_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      load_cnt   <= '0;
      occ        <= '0;
      rd_pipe    <= '0;
      ack        <= 1'b0;
      wren       <= 1'b0;
      cof        <= 1'b0;
      of_ev      <= 1'b0;
      flush_drop <= 1'b0;
      clauses_q  <= '0;
      mask_q     <= '0;
    end else begin
      ack   <= 1'b0;
      wren  <= 1'b0;
      cof   <= 1'b0;
      of_ev <= 1'b0;
      occ   <= occ_next;
      rd_pipe[0] <= rden;
      for (int i = 1; i < RD_LAT; i++)
        rd_pipe[i] <= rd_pipe[i-1];
      if (bus.flush_i) begin
        state      <= RECOVER;
        flush_drop <= 1'b1;
      // OF may still read high while the cof pulse takes effect.
      end else if (bus.tree_of_i && state != RECOVER && !cof) begin
        state <= RECOVER;
        of_ev <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (accept) begin
              ack       <= 1'b1;
              clauses_q <= bus.batch_clauses_i;
              mask_q    <= bus.batch_mask_i;
              if (bus.batch_mask_i != '0) begin
                wren     <= 1'b1;
                state    <= LOAD;
                load_cnt <= 3'(LOAD_CYCLES - 1);
              end
            end
          end
          LOAD: begin
            if (load_cnt == '0)
              state <= IDLE;
            else
              load_cnt <= load_cnt - 3'd1;
          end
          RECOVER: begin
            if (bus.tree_empty_i && inflight == 0) begin
              cof        <= 1'b1;
              occ        <= '0;
              flush_drop <= 1'b0;
              state      <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.batch_ack_o    = ack;
  assign bus.tree_clauses_o = clauses_q;
  assign bus.tree_mask_o    = mask_q;
  assign bus.tree_wren_o    = wren;
  assign bus.tree_rden_o    = rden;
  assign bus.tree_cof_o     = cof;
  assign bus.of_event_o     = of_ev;
  assign bus.occ_o          = occ;
  assign bus.busy_o         = (state != IDLE) || (occ != '0);

`ifdef FIFO_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      batch_count_o      <= '0;
      clause_in_count_o  <= '0;
      clause_out_count_o <= '0;
      of_count_o         <= '0;
    end else begin
      if (accept) begin
        batch_count_o     <= batch_count_o + 32'd1;
        clause_in_count_o <= clause_in_count_o + 32'(pop_cnt);
      end
      if (bus.clause_valid_o && bus.clause_ready_i)
        clause_out_count_o <= clause_out_count_o + 32'd1;
      if (of_ev)
        of_count_o <= of_count_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_tree_sched.sv
// Directed bench for fifo_tree_sched with a queue-based tree model.
// Table of batch vectors plus stall, backpressure, OF, flush, reset cases.
module tb_fifo_tree_sched;
  import fifo_tree_pkg::*;

  localparam int CC  = 20;
  localparam int CW  = 36;
  localparam int LIM = 24;
  localparam int SKD = 4;
  localparam int OW  = $clog2(LIM + CC) + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fifo_tree_sched_if #(.CW(CW), .CC(CC), .OW(OW)) bus ();

`ifdef FIFO_SCHED_STATS_EN
  logic [31:0] bc, cic, coc;
  logic [15:0] ofc;
`endif

  fifo_tree_sched #(
    .CLAUSE_COUNT (CC),
    .CLAUSE_WIDTH (CW),
    .OCC_LIMIT    (LIM),
    .RD_LAT       (1),
    .SKID_DEPTH   (SKD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef FIFO_SCHED_STATS_EN
    ,
    .batch_count_o      (bc),
    .clause_in_count_o  (cic),
    .clause_out_count_o (coc),
    .of_count_o         (ofc)
`endif
  );

  // Tree model: one FIFO, data valid the cycle after rden.
  logic [CW-1:0] tq[$];
  int rd_total;
  always @(posedge clk) begin
    if (reset) begin
      tq.delete();
      bus.tree_empty_i  <= 1'b1;
      bus.tree_clause_i <= '0;
      rd_total          <= 0;
    end else begin
      if (bus.tree_rden_o) begin
        if (tq.size() > 0)
          bus.tree_clause_i <= tq.pop_front();
        rd_total <= rd_total + 1;
      end
      if (bus.tree_wren_o)
        for (int i = 0; i < CC; i++)
          if (bus.tree_mask_o[i])
            tq.push_back(bus.tree_clauses_o[i*CW +: CW]);
      bus.tree_empty_i <= (tq.size() == 0);
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  logic [CW-1:0] eq[$];
  int npop = 0;
  int rmode = 1;
  bit pv, pr, trk;
  logic [CW-1:0] pc;
  int stall_err = 0;
  int maxout = 0;

  task automatic check(input string nm,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] cv(int b, int i);
    return CW'(64'h9_0000_0000 | (64'(b) << 8) | 64'(i));
  endfunction

  task automatic tick();
    @(negedge clk);
    if (pv && !pr && !bus.flush_i && !reset)
      if (!bus.clause_valid_o || bus.clause_o != pc)
        stall_err++;
    case (rmode)
      0:       bus.clause_ready_i = 1'b0;
      1:       bus.clause_ready_i = 1'b1;
      default: bus.clause_ready_i = ~bus.clause_ready_i;
    endcase
    if (bus.clause_valid_o && bus.clause_ready_i) begin
      check("clause_avail", eq.size() != 0, 1);
      if (eq.size() != 0)
        check("clause", bus.clause_o, eq.pop_front());
      npop++;
    end
    pv = bus.clause_valid_o;
    pr = bus.clause_ready_i;
    pc = bus.clause_o;
    if (trk && rd_total - npop > maxout)
      maxout = rd_total - npop;
  endtask

  task automatic offer(input int b, input logic [CC-1:0] m);
    for (int i = 0; i < CC; i++)
      bus.batch_clauses_i[i*CW +: CW] = cv(b, i);
    bus.batch_mask_i = m;
    bus.batch_req_i  = 1'b1;
  endtask

  task automatic take();
    for (int i = 0; i < CC; i++)
      if (bus.batch_mask_i[i])
        eq.push_back(bus.batch_clauses_i[i*CW +: CW]);
    bus.batch_req_i = 1'b0;
  endtask

  task automatic wait_ack(input int lim, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.batch_ack_o && n < lim);
    check("ack_seen", bus.batch_ack_o, 1);
    if (bus.batch_ack_o) take();
    bus.batch_req_i = 1'b0;
  endtask

  task automatic drain(input int lim);
    int n, quiet;
    n = 0;
    quiet = 0;
    while (quiet < 3 && n < lim) begin
      tick();
      n++;
      if (!bus.busy_o && !bus.clause_valid_o) quiet++;
      else quiet = 0;
    end
    check("drain_done", quiet, 3);
  endtask

  typedef struct {
    logic [CC-1:0] mask;
    int            cnt;
    logic          wren;
  } vec_t;

  vec_t tv[6];

  initial begin
    int n, base, acks, cofs, ofs, vseen, wrens;
    bit early;
    logic [OW-1:0] occ_prev;

    tv[0] = '{20'hFFFFF, 20, 1'b1};
    tv[1] = '{20'h00421, 3, 1'b1};
    tv[2] = '{20'h00000, 0, 1'b0};
    tv[3] = '{20'h80001, 2, 1'b1};
    tv[4] = '{20'hAAAAA, 10, 1'b1};
    tv[5] = '{20'h0F0F0, 8, 1'b1};

    bus.batch_clauses_i = '0;
    bus.batch_mask_i    = '0;
    bus.batch_req_i     = 1'b0;
    bus.flush_i         = 1'b0;
    bus.tree_of_i       = 1'b0;
    bus.clause_ready_i  = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_ack",   bus.batch_ack_o, 0);
    check("rst_wren",  bus.tree_wren_o, 0);
    check("rst_rden",  bus.tree_rden_o, 0);
    check("rst_cof",   bus.tree_cof_o, 0);
    check("rst_valid", bus.clause_valid_o, 0);
    check("rst_clause", bus.clause_o, 0);
    check("rst_busy",  bus.busy_o, 0);
    check("rst_ofev",  bus.of_event_o, 0);
    check("rst_occ",   bus.occ_o, 0);
    check("rst_mask",  bus.tree_mask_o, 0);
    check("rst_tcl",   |bus.tree_clauses_o, 0);
    reset = 1'b0;

    // Single batches from the table.
    rmode = 1;
    for (int k = 0; k < 6; k++) begin
      base = npop;
      offer(k, tv[k].mask);
      wait_ack(10, n);
      check("ack_lat", n, 1);
      check("wren", bus.tree_wren_o, tv[k].wren);
      check("occ_ack", bus.occ_o, tv[k].cnt);
      tick();
      check("wren_1cyc", bus.tree_wren_o, 0);
      drain(200);
      check("nout", npop - base, tv[k].cnt);
      check("occ_end", bus.occ_o, 0);
      check("busy_end", bus.busy_o, 0);
    end

    // Admission stall with consumer blocked.
    base = npop;
    rmode = 0;
    offer(10, 20'hFFFFF);
    wait_ack(10, n);
    offer(11, 20'hFFFFF);
    acks = 0;
    repeat (15) begin
      tick();
      if (bus.batch_ack_o) acks++;
    end
    check("stall_noack", acks, 0);
    check("stall_occ", bus.occ_o, 20 - SKD);
    rmode = 1;
    n = 0;
    do begin
      occ_prev = bus.occ_o;
      tick();
      n++;
    end while (!bus.batch_ack_o && n < 200);
    check("stall_ack", bus.batch_ack_o, 1);
    check("admit_occ", occ_prev, 4);
    take();
    drain(300);
    check("stall_nout", npop - base, 40);

    // Backpressure with ready toggling each cycle.
    base = npop;
    rmode = 2;
    trk = 1'b1;
    stall_err = 0;
    offer(20, 20'hFFFFF);
    wait_ack(10, n);
    offer(21, 20'hFFFFF);
    wait_ack(300, n);
    drain(400);
    trk = 1'b0;
    check("bp_nout", npop - base, 40);
    check("bp_stable", stall_err, 0);
    check("bp_skid_max", maxout <= SKD, 1);

    // Overflow mid-LOAD.
    base = npop;
    rmode = 1;
    offer(30, 20'hFFFFF);
    wait_ack(10, n);
    tick();
    tick();
    bus.tree_of_i = 1'b1;
    offer(31, 20'h00421);
    tick();
    bus.tree_of_i = 1'b0;
    check("of_event", bus.of_event_o, 1);
    early = bus.batch_ack_o;
    tick();
    check("of_pulse1", bus.of_event_o, 0);
    cofs = 0;
    ofs = 0;
    acks = 0;
    for (int i = 0; i < 200 && acks == 0; i++) begin
      if (bus.of_event_o) ofs++;
      if (bus.tree_cof_o) begin
        cofs++;
        check("of_occ0", bus.occ_o, 0);
      end
      if (bus.batch_ack_o) begin
        if (cofs == 0) early = 1'b1;
        acks++;
        take();
      end else begin
        tick();
      end
    end
    bus.batch_req_i = 1'b0;
    check("of_ack_after", acks, 1);
    check("of_no_early", early, 0);
    check("of_cof_once", cofs, 1);
    check("of_ev_once", ofs, 0);
    drain(200);
    check("of_nout", npop - base, 23);

    // Flush with 8 clauses queued.
    rmode = 0;
    offer(40, 20'h000FF);
    wait_ack(10, n);
    repeat (10) tick();
    check("fl_pre_valid", bus.clause_valid_o, 1);
    check("fl_pre_occ", bus.occ_o, 4);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    eq.delete();
    check("fl_valid0", bus.clause_valid_o, 0);
    rmode = 1;
    cofs = 0;
    ofs = 0;
    vseen = 0;
    repeat (30) begin
      if (bus.tree_cof_o) cofs++;
      if (bus.of_event_o) ofs++;
      if (bus.clause_valid_o) vseen++;
      tick();
    end
    check("fl_cof_once", cofs, 1);
    check("fl_no_of", ofs, 0);
    check("fl_no_valid", vseen, 0);
    check("fl_occ", bus.occ_o, 0);
    check("fl_busy", bus.busy_o, 0);

    // Reset in the middle of LOAD.
    offer(50, 20'hFFFFF);
    wait_ack(10, n);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    eq.delete();
    acks = 0;
    wrens = 0;
    repeat (20) begin
      tick();
      if (bus.batch_ack_o) acks++;
      if (bus.tree_wren_o) wrens++;
    end
    check("rl_noack", acks, 0);
    check("rl_nowren", wrens, 0);
    check("rl_occ", bus.occ_o, 0);
    check("rl_valid", bus.clause_valid_o, 0);
    check("rl_busy", bus.busy_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
